// File: rtl/core_mc.sv
// Multi-cycle RV32I-subset core with req/ack instruction and data ports.
// SYSTEM opcode (ecall/ebreak) is the halt instruction; unrecognised opcodes retire as no-ops.
module core_mc #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned PC_INC    = 1,
  parameter int unsigned IMM_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] last_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [1:0]      dmem_width,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retired,
  output logic            halted
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [31:0]     r_ir, w_ir_nxt;
  logic            r_imem_req, w_imem_req_nxt;
  logic            r_dmem_req, w_dmem_req_nxt;
  logic            r_dmem_we, w_dmem_we_nxt;
  logic [1:0]      r_dmem_width, w_dmem_width_nxt;
  logic [XLEN-1:0] r_dmem_addr, w_dmem_addr_nxt;
  logic [XLEN-1:0] r_dmem_wdata, w_dmem_wdata_nxt;
  logic            r_retired, w_retired_nxt;
  logic            r_halted, w_halted_nxt;
  logic [XLEN-1:0] r_wb_val, w_wb_val_nxt;
  logic [XLEN-1:0] r_next_pc, w_next_pc_nxt;
  logic            r_rf_we, w_rf_we_nxt;
  logic            r_halt_req, w_halt_req_nxt;
  logic [4:0]      r_rd, w_rd_nxt;
  logic [2:0]      r_ld_f3, w_ld_f3_nxt;
  logic            w_rf_wen;
  logic [XLEN-1:0] r_regs [32];

  logic [6:0]             w_opc;
  logic [4:0]             w_rs1_idx, w_rs2_idx;
  logic [2:0]             w_f3;
  logic                   w_f7b5;
  logic signed [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic signed [XLEN-1:0] w_off_i, w_off_b, w_off_j;
  logic [XLEN-1:0]        w_rs1, w_rs2, w_opb, w_alu, w_pc_inc, w_ld_ext;
  logic [SHW-1:0]         w_shamt;
  logic                   w_br_cond, w_is_mem;

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_width = r_dmem_width;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign retired    = r_retired;
  assign halted     = r_halted;

  // Instruction field decode and sign-extended immediates
  assign w_opc     = r_ir[6:0];
  assign w_rs1_idx = r_ir[19:15];
  assign w_rs2_idx = r_ir[24:20];
  assign w_f3      = r_ir[14:12];
  assign w_f7b5    = r_ir[30];
  assign w_imm_i   = XLEN'($signed(r_ir[31:20]));
  assign w_imm_s   = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
  assign w_imm_b   = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
  assign w_imm_j   = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));
  assign w_imm_u   = XLEN'($signed({r_ir[31:12], 12'b0}));
  assign w_off_i   = w_imm_i >>> IMM_SHIFT;
  assign w_off_b   = w_imm_b >>> IMM_SHIFT;
  assign w_off_j   = w_imm_j >>> IMM_SHIFT;
  assign w_pc_inc  = r_pc + XLEN'(PC_INC);
  assign w_rs1     = (w_rs1_idx == 5'd0) ? '0 : r_regs[w_rs1_idx];
  assign w_rs2     = (w_rs2_idx == 5'd0) ? '0 : r_regs[w_rs2_idx];
  assign w_is_mem  = (w_opc == OP_LOAD) || (w_opc == OP_STORE);

  // ALU and branch comparator
  always_comb begin
    w_opb   = (w_opc == OP_REG) ? w_rs2 : $unsigned(w_imm_i);
    w_shamt = w_opb[SHW-1:0];
    case (w_f3)
      3'b000:  w_alu = (w_opc == OP_REG && w_f7b5) ? w_rs1 - w_opb : w_rs1 + w_opb;
      3'b001:  w_alu = w_rs1 << w_shamt;
      3'b010:  w_alu = XLEN'($signed(w_rs1) < $signed(w_opb));
      3'b011:  w_alu = XLEN'(w_rs1 < w_opb);
      3'b100:  w_alu = w_rs1 ^ w_opb;
      3'b101:  w_alu = w_f7b5 ? XLEN'($signed(w_rs1) >>> w_shamt) : w_rs1 >> w_shamt;
      3'b110:  w_alu = w_rs1 | w_opb;
      default: w_alu = w_rs1 & w_opb;
    endcase
    case (w_f3)
      3'b000:  w_br_cond = (w_rs1 == w_rs2);
      3'b001:  w_br_cond = (w_rs1 != w_rs2);
      3'b100:  w_br_cond = ($signed(w_rs1) < $signed(w_rs2));
      3'b101:  w_br_cond = ($signed(w_rs1) >= $signed(w_rs2));
      3'b110:  w_br_cond = (w_rs1 < w_rs2);
      3'b111:  w_br_cond = (w_rs1 >= w_rs2);
      default: w_br_cond = 1'b0;
    endcase
  end

  // Load data extension by the funct3 latched in EXEC
  always_comb begin
    case (r_ld_f3)
      3'b000:  w_ld_ext = XLEN'($signed(dmem_rdata[7:0]));
      3'b001:  w_ld_ext = XLEN'($signed(dmem_rdata[15:0]));
      3'b100:  w_ld_ext = XLEN'(dmem_rdata[7:0]);
      3'b101:  w_ld_ext = XLEN'(dmem_rdata[15:0]);
      default: w_ld_ext = dmem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ir_nxt         = r_ir;
    w_imem_req_nxt   = 1'b0;
    w_dmem_req_nxt   = 1'b0;
    w_dmem_we_nxt    = r_dmem_we;
    w_dmem_width_nxt = r_dmem_width;
    w_dmem_addr_nxt  = r_dmem_addr;
    w_dmem_wdata_nxt = r_dmem_wdata;
    w_retired_nxt    = 1'b0;
    w_halted_nxt     = r_halted;
    w_wb_val_nxt     = r_wb_val;
    w_next_pc_nxt    = r_next_pc;
    w_rf_we_nxt      = r_rf_we;
    w_halt_req_nxt   = r_halt_req;
    w_rd_nxt         = r_rd;
    w_ld_f3_nxt      = r_ld_f3;
    w_rf_wen         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt    = S_FETCH;
        w_imem_req_nxt = 1'b1;
      end
      S_FETCH: begin
        if (r_imem_req && imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_state_nxt = S_EXEC;
        end else begin
          w_imem_req_nxt = 1'b1;
        end
      end
      S_EXEC: begin
        w_rd_nxt       = r_ir[11:7];
        w_ld_f3_nxt    = w_f3;
        w_halt_req_nxt = (w_opc == OP_SYSTEM);
        w_rf_we_nxt    = 1'b0;
        w_wb_val_nxt   = w_alu;
        w_next_pc_nxt  = w_pc_inc;
        case (w_opc)
          OP_IMM, OP_REG, OP_LOAD: w_rf_we_nxt = 1'b1;
          OP_LUI: begin
            w_rf_we_nxt  = 1'b1;
            w_wb_val_nxt = $unsigned(w_imm_u);
          end
          OP_JAL: begin
            w_rf_we_nxt   = 1'b1;
            w_wb_val_nxt  = w_pc_inc;
            w_next_pc_nxt = r_pc + $unsigned(w_off_j);
          end
          OP_JALR: begin
            w_rf_we_nxt   = 1'b1;
            w_wb_val_nxt  = w_pc_inc;
            w_next_pc_nxt = w_rs1 + $unsigned(w_off_i);
          end
          OP_BRANCH: if (w_br_cond) w_next_pc_nxt = r_pc + $unsigned(w_off_b);
          default: ;
        endcase
        if (w_is_mem) begin
          w_dmem_req_nxt   = 1'b1;
          w_dmem_we_nxt    = (w_opc == OP_STORE);
          w_dmem_width_nxt = w_f3[1:0];
          w_dmem_addr_nxt  = w_rs1 + $unsigned((w_opc == OP_STORE) ? w_imm_s : w_imm_i);
          w_dmem_wdata_nxt = w_rs2;
          w_state_nxt      = S_MEM;
        end else begin
          w_retired_nxt = 1'b1;
          w_state_nxt   = S_WB;
        end
      end
      S_MEM: begin
        if (r_dmem_req && dmem_ack) begin
          if (!r_dmem_we) w_wb_val_nxt = w_ld_ext;
          w_retired_nxt = 1'b1;
          w_state_nxt   = S_WB;
        end else begin
          w_dmem_req_nxt = 1'b1;
        end
      end
      S_WB: begin
        w_rf_wen = r_rf_we;
        w_pc_nxt = r_next_pc;
        if (r_halt_req || r_pc == last_pc) begin
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_HALT;
        end else begin
          w_imem_req_nxt = 1'b1;
          w_state_nxt    = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= XLEN'(RESET_PC);
      r_ir         <= '0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_width <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_retired    <= 1'b0;
      r_halted     <= 1'b0;
      r_wb_val     <= '0;
      r_next_pc    <= '0;
      r_rf_we      <= 1'b0;
      r_halt_req   <= 1'b0;
      r_rd         <= '0;
      r_ld_f3      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ir         <= w_ir_nxt;
      r_imem_req   <= w_imem_req_nxt;
      r_dmem_req   <= w_dmem_req_nxt;
      r_dmem_we    <= w_dmem_we_nxt;
      r_dmem_width <= w_dmem_width_nxt;
      r_dmem_addr  <= w_dmem_addr_nxt;
      r_dmem_wdata <= w_dmem_wdata_nxt;
      r_retired    <= w_retired_nxt;
      r_halted     <= w_halted_nxt;
      r_wb_val     <= w_wb_val_nxt;
      r_next_pc    <= w_next_pc_nxt;
      r_rf_we      <= w_rf_we_nxt;
      r_halt_req   <= w_halt_req_nxt;
      r_rd         <= w_rd_nxt;
      r_ld_f3      <= w_ld_f3_nxt;
    end
  end

  // Register file: contents survive reset; x0 writes dropped
  always_ff @(posedge clk) begin
    if (!rst && w_rf_wen && r_rd != 5'd0) r_regs[r_rd] <= r_wb_val;
  end
endmodule

// File: tb/tb_core_mc.sv
// Directed bench for core_mc: word-indexed core plus a byte-addressed instance for branch scaling.
module tb_core_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, d_force, log_clr;
  logic [31:0] last_pc;
  int          i_lat, d_lat, i_cnt, d_cnt;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retired, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  dmem_width;
  logic [31:0] imem [64];

  logic        imem_req_b, dmem_req_b, dmem_we_b, retired_b, halted_b;
  logic [31:0] imem_addr_b, imem_rdata_b, dmem_addr_b, dmem_wdata_b;
  logic [1:0]  dmem_width_b;
  logic [31:0] imem_b [64];

  logic [31:0] fa [16];
  logic [31:0] fb [16];
  logic [31:0] da_addr [16];
  logic [31:0] da_wdata [16];
  logic        da_we [16];
  logic [1:0]  da_w [16];
  int          fa_n, fb_n, da_n;
  int          checks, failures;

  core_mc u_dut (
    .clk(clk), .rst(rst), .last_pc(last_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_width(dmem_width), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retired(retired), .halted(halted)
  );

  core_mc #(.XLEN(32), .RESET_PC(20), .PC_INC(4), .IMM_SHIFT(0)) u_dut_b (
    .clk(clk), .rst(rst), .last_pc(32'hFFFF_FFFF),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_req_b), .imem_rdata(imem_rdata_b),
    .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_width(dmem_width_b), .dmem_addr(dmem_addr_b),
    .dmem_wdata(dmem_wdata_b), .dmem_ack(dmem_req_b), .dmem_rdata(32'h0),
    .retired(retired_b), .halted(halted_b)
  );

  assign imem_rdata   = imem[imem_addr[5:0]];
  assign imem_rdata_b = imem_b[imem_addr_b[7:2]];
  assign imem_ack     = imem_req && (i_cnt >= i_lat);
  assign dmem_ack     = d_force || (dmem_req && (d_cnt >= d_lat));
  assign dmem_rdata   = 32'h0000_0080;

  // Wait-state counters and transaction logs
  always @(posedge clk) begin
    i_cnt <= (rst || !imem_req || imem_ack) ? 0 : i_cnt + 1;
    d_cnt <= (rst || !dmem_req || dmem_ack) ? 0 : d_cnt + 1;
    if (log_clr) begin
      fa_n <= 0; fb_n <= 0; da_n <= 0;
    end else begin
      if (imem_req && imem_ack && fa_n < 16) begin fa[fa_n] <= imem_addr; fa_n <= fa_n + 1; end
      if (imem_req_b && fb_n < 16) begin fb[fb_n] <= imem_addr_b; fb_n <= fb_n + 1; end
      if (dmem_req && dmem_ack && da_n < 16) begin
        da_addr[da_n] <= dmem_addr; da_wdata[da_n] <= dmem_wdata;
        da_we[da_n] <= dmem_we; da_w[da_n] <= dmem_width; da_n <= da_n + 1;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1; log_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; log_clr = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic test_reset();
    fill_nop(); last_pc = 32'd0; i_lat = 0; d_lat = 0;
    apply_reset();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL reset_pc got %h want 0", imem_addr); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin failures++; $display("FAIL reset_dmem_req_we got %b%b want 00", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 || dmem_width !== 2'd0) begin
      failures++; $display("FAIL reset_dmem_regs got %h %h %0d want 0 0 0", dmem_addr, dmem_wdata, dmem_width); end
    checks++; if (retired !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_ret_halt got %b%b want 00", retired, halted); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_a;
    fill_nop();
    imem[0] = 32'h0050_0093;  // addi x1,x0,5
    imem[1] = 32'h0030_8113;  // addi x2,x1,3
    last_pc = 32'd1;
    apply_reset();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checks++; if (retired !== (c == 3 || c == 6)) begin failures++; $display("FAIL basic_retired cycle %0d got %b", c, retired); end
      checks++; if (halted !== (c >= 7)) begin failures++; $display("FAIL basic_halted cycle %0d got %b", c, halted); end
      if (c == 1 || c == 4) begin
        exp_a = (c == 1) ? 32'd0 : 32'd1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_a) begin
          failures++; $display("FAIL basic_fetch cycle %0d got req=%b addr=%h want 1 %h", c, imem_req, imem_addr, exp_a); end
      end
    end
  endtask

  task automatic test_imem_wait();
    fill_nop();
    imem[0] = 32'h0050_0093;
    last_pc = 32'd0; i_lat = 4;
    apply_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (imem_req !== (c <= 5)) begin failures++; $display("FAIL wait_req cycle %0d got %b", c, imem_req); end
      if (c <= 5) begin
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL wait_addr cycle %0d got %h want 0", c, imem_addr); end
      end
      checks++; if (retired !== (c == 7)) begin failures++; $display("FAIL wait_retired cycle %0d got %b", c, retired); end
    end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL wait_halted got %b want 1", halted); end
    i_lat = 0;
  endtask

  task automatic test_load_store();
    logic [31:0] e_addr [5] = '{32'd8, 32'd8, 32'd12, 32'd8, 32'd12};
    logic [31:0] e_wd   [5] = '{32'd8, 32'd0, 32'hFFFF_FF80, 32'd0, 32'h0000_0080};
    logic        e_we   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  e_w    [5] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
    int c = 0;
    fill_nop();
    imem[0] = 32'h0020_2423;  // sw  x2,8(x0)
    imem[1] = 32'h0080_0183;  // lb  x3,8(x0)
    imem[2] = 32'h0030_2623;  // sw  x3,12(x0)
    imem[3] = 32'h0080_4183;  // lbu x3,8(x0)
    imem[4] = 32'h0030_2623;  // sw  x3,12(x0)
    imem[5] = 32'h0000_0073;  // ecall -> halt
    last_pc = 32'd63; d_lat = 1;
    apply_reset();
    while (!halted && c < 60) begin @(negedge clk); c++; end
    checks++; if (c !== 29) begin failures++; $display("FAIL ls_halt_cycle got %0d want 29", c); end
    checks++; if (da_n !== 5) begin failures++; $display("FAIL ls_access_count got %0d want 5", da_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (da_we[i] !== e_we[i] || da_addr[i] !== e_addr[i] || da_w[i] !== e_w[i] || (e_we[i] && da_wdata[i] !== e_wd[i])) begin
        failures++;
        $display("FAIL ls_access%0d got we=%b addr=%h w=%0d wd=%h want we=%b addr=%h w=%0d wd=%h",
                 i, da_we[i], da_addr[i], da_w[i], da_wdata[i], e_we[i], e_addr[i], e_w[i], e_wd[i]);
      end
    end
    d_lat = 0;
  endtask

  task automatic test_branch_jump();
    logic [31:0] e_f [9] = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd3, 32'd4, 32'd3, 32'd4, 32'd3};
    int c = 0;
    fill_nop();
    imem[2] = 32'h00C0_00EF;  // jal  x1,+12
    imem[3] = 32'h0010_2823;  // sw   x1,16(x0)
    imem[4] = 32'h0000_8067;  // jalr x0,0(x1)
    imem[5] = 32'hFE00_0CE3;  // beq  x0,x0,-8
    last_pc = 32'd63;
    apply_reset();
    while (fa_n < 9 && c < 80) begin @(negedge clk); c++; end
    for (int i = 0; i < 9; i++) begin
      checks++; if (fa[i] !== e_f[i]) begin failures++; $display("FAIL bj_fetch%0d got %h want %h", i, fa[i], e_f[i]); end
    end
    checks++; if (da_addr[0] !== 32'd16 || da_wdata[0] !== 32'd3) begin
      failures++; $display("FAIL bj_link got addr=%h wd=%h want 10 3", da_addr[0], da_wdata[0]); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL bj_halted got %b want 0", halted); end
  endtask

  task automatic test_byte_pc();
    int c = 0;
    apply_reset();
    while (!halted_b && c < 40) begin @(negedge clk); c++; end
    checks++; if (fb_n !== 2) begin failures++; $display("FAIL bpc_fetch_count got %0d want 2", fb_n); end
    checks++; if (fb[0] !== 32'd20 || fb[1] !== 32'd12) begin
      failures++; $display("FAIL bpc_fetch got %0d,%0d want 20,12", fb[0], fb[1]); end
    checks++; if (halted_b !== 1'b1) begin failures++; $display("FAIL bpc_halted got %b want 1", halted_b); end
  endtask

  task automatic test_reset_mid_mem();
    int c = 0;
    fill_nop();
    imem[0] = 32'h0080_0183;  // lb x3,8(x0), left pending
    last_pc = 32'd63; d_lat = 15;
    apply_reset();
    while (!dmem_req && c < 10) begin @(negedge clk); c++; end
    checks++; if (c !== 3) begin failures++; $display("FAIL rm_mem_entry got cycle %0d want 3", c); end
    rst = 1'b1; log_clr = 1'b1; d_lat = 0;
    imem[0] = 32'h0030_2623;  // sw x3,12(x0)
    imem[1] = 32'h0000_0073;
    @(negedge clk);
    rst = 1'b0; log_clr = 1'b0; d_force = 1'b1;
    checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0 || retired !== 1'b0) begin
      failures++; $display("FAIL rm_idle got dreq=%b ireq=%b ret=%b want 000", dmem_req, imem_req, retired); end
    @(negedge clk);
    d_force = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      failures++; $display("FAIL rm_refetch got req=%b addr=%h want 1 0", imem_req, imem_addr); end
    c = 0;
    while (!halted && c < 40) begin @(negedge clk); c++; end
    checks++; if (da_n !== 1 || da_we[0] !== 1'b1 || da_wdata[0] !== 32'h0000_0080) begin
      failures++; $display("FAIL rm_x3_kept got n=%0d we=%b wd=%h want 1 1 00000080", da_n, da_we[0], da_wdata[0]); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; d_force = 1'b0; log_clr = 1'b1; last_pc = 32'd0; i_lat = 0; d_lat = 0;
    for (int i = 0; i < 64; i++) imem_b[i] = 32'h0000_0013;
    imem_b[5] = 32'hFE00_0CE3;  // beq x0,x0,-8 at byte pc 20
    imem_b[3] = 32'h0000_0073;  // ecall at byte pc 12
    test_reset();
    test_basic();
    test_imem_wait();
    test_load_store();
    test_branch_jump();
    test_byte_pc();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
